// File: rtl/dptr_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : dptr_multiciclo_if
// Description : Instruction-memory ready/valid port used by dptr_multiciclo.
//               master : datapath side (issues imem_req / imem_addr)
//               slave  : memory side   (returns imem_ready / imem_data)
//   imem_req    1      fetch request, held until accepted
//   imem_addr   WIDTH  fetch address (equals the datapath pc)
//   imem_ready  1      instruction word valid this cycle
//   imem_data   32     instruction word
// Revision    : 1.0  initial release
// ============================================================================
interface dptr_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic [31:0]      imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface
`default_nettype wire

// File: rtl/dptr_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : dptr_multiciclo
// Description : Multi-cycle MIPS-subset datapath (FETCH/DECODE/EXEC/WB|BRANCH)
//               with register file, ALU, ALU control, PC, illegal-op trap and
//               a combinational debug register read port.
// Ports       : clk, rst        clock, synchronous active-high reset
//               run             execution enable (IDLE / instruction end)
//               imem            instruction-fetch port (master modport)
//               pc              current PC
//               retired         one-cycle pulse per completed instruction
//               zf              zero flag of the last EXEC
//               illegal         sticky unsupported op/funct flag
//               dbg_sel/dbg_data debug register read
// Revision    : 1.0  initial release
// ============================================================================
module dptr_multiciclo #(
    parameter int               WIDTH    = 32,
    parameter int               NREG     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      run,
    dptr_multiciclo_if.master        imem,
    output logic [WIDTH-1:0]         pc,
    output logic                     retired,
    output logic                     zf,
    output logic                     illegal,
    input  wire  [$clog2(NREG)-1:0]  dbg_sel,
    output logic [WIDTH-1:0]         dbg_data
);
    localparam int AW = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [WIDTH-1:0] C_PC_STEP = WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [31:0]      ir_q, ir_d;
    logic             zf_q, zf_d;
    logic             illegal_q, illegal_d;
    logic             retired_q, retired_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    // Instruction fields
    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [4:0]    w_shamt;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_dst;
    logic [31:0]   w_imm_sext32;
    logic [31:0]   w_imm_zext32;
    logic [31:0]   w_br_off32;

    assign w_op         = ir_q[31:26];
    assign w_funct      = ir_q[5:0];
    assign w_shamt      = ir_q[10:6];
    assign w_rs         = ir_q[21 +: AW];
    assign w_rt         = ir_q[16 +: AW];
    assign w_rd         = ir_q[11 +: AW];
    // R-type writes rd, the I-type ALU ops write rt
    assign w_dst        = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_imm_sext32 = {{16{ir_q[15]}}, ir_q[15:0]};
    assign w_imm_zext32 = {16'h0000, ir_q[15:0]};
    assign w_br_off32   = {w_imm_sext32[29:0], 2'b00};

    // ALU and ALU control
    logic [WIDTH-1:0] w_alu_res;
    logic             w_legal;
    logic             w_is_branch;
    logic             w_slt;
    logic             w_taken;

    assign w_slt   = $signed(a_q) < $signed(b_q);
    // zf_q holds rs-rt from the EXEC of this same branch
    assign w_taken = (w_op == OP_BEQ) ? zf_q : ~zf_q;

    always_comb begin
        w_alu_res   = '0;
        w_legal     = 1'b0;
        w_is_branch = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD: begin w_alu_res = a_q + b_q; w_legal = 1'b1; end
                    F_SUB: begin w_alu_res = a_q - b_q; w_legal = 1'b1; end
                    F_AND: begin w_alu_res = a_q & b_q; w_legal = 1'b1; end
                    F_OR:  begin w_alu_res = a_q | b_q; w_legal = 1'b1; end
                    F_SLT: begin
                        w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
                        w_legal   = 1'b1;
                    end
                    F_SLL: begin
                        // Shift amounts reaching the datapath width clear the result
                        w_alu_res = (32'(w_shamt) >= 32'(WIDTH)) ? '0 : (b_q << w_shamt);
                        w_legal   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                w_alu_res = a_q + w_imm_sext32[WIDTH-1:0];
                w_legal   = 1'b1;
            end
            OP_ANDI: begin
                w_alu_res = a_q & w_imm_zext32[WIDTH-1:0];
                w_legal   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_alu_res   = a_q - b_q;
                w_legal     = 1'b1;
                w_is_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state / datapath control
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        zf_d      = zf_q;
        illegal_d = illegal_q;
        retired_d = 1'b0;
        regs_d    = regs_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ready) begin
                    ir_d    = imem.imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[w_rs];
                b_d     = regs_q[w_rt];
                pc_d    = pc_q + C_PC_STEP;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!w_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    alu_d   = w_alu_res;
                    zf_d    = (w_alu_res == '0);
                    state_d = w_is_branch ? S_BRANCH : S_WB;
                end
            end
            S_WB: begin
                regs_d[w_dst] = alu_q;
                regs_d[0]     = '0;
                retired_d     = 1'b1;
                state_d       = run ? S_FETCH : S_IDLE;
            end
            S_BRANCH: begin
                // pc already points past the branch
                if (w_taken) pc_d = pc_q + w_br_off32[WIDTH-1:0];
                retired_d = 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            zf_q      <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            zf_q      <= zf_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign retired        = retired_q;
    assign zf             = zf_q;
    assign illegal        = illegal_q;
    assign dbg_data       = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_dptr_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_dptr_multiciclo
// Description : Directed self-checking bench for dptr_multiciclo. A 32-bit
//               instance runs the ALU, branch, stall and illegal/reset
//               sequences; an 8-bit / 8-register instance runs the width,
//               wrap and register-index sequence.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dptr_multiciclo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, run8, ready32, ready8;
    logic [4:0]  dbg_sel;
    logic [2:0]  dbg_sel8;
    logic [31:0] pc, dbg_data;
    logic        retired, zf, illegal;
    logic [7:0]  pc8, dbg_data8;
    logic        retired8, zf8, illegal8;

    logic [31:0] mem32 [64];
    logic [31:0] mem8  [64];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_cyc = 0;
    int prev_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dptr_multiciclo_if #(.WIDTH(32)) if32 ();
    dptr_multiciclo_if #(.WIDTH(8))  if8 ();

    assign if32.imem_ready = ready32;
    assign if32.imem_data  = mem32[if32.imem_addr[7:2]];
    assign if8.imem_ready  = ready8;
    assign if8.imem_data   = mem8[if8.imem_addr[7:2]];

    dptr_multiciclo #(.WIDTH(32), .NREG(32), .RESET_PC(32'h0)) u_dut32 (
        .clk(clk), .rst(rst), .run(run), .imem(if32.master),
        .pc(pc), .retired(retired), .zf(zf), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    dptr_multiciclo #(.WIDTH(8), .NREG(8), .RESET_PC(8'hF4)) u_dut8 (
        .clk(clk), .rst(rst), .run(run8), .imem(if8.master),
        .pc(pc8), .retired(retired8), .zf(zf8), .illegal(illegal8),
        .dbg_sel(dbg_sel8), .dbg_data(dbg_data8)
    );

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                          input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ret(input bit d8, input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = d8 ? retired8 : retired;
        end
        check({tag, "_retired"}, 32'(seen), 32'd1);
        prev_cyc = last_cyc;
        last_cyc = cyc;
    endtask

    task automatic rd32(input int sel, input logic [31:0] exp, input string tag);
        dbg_sel = 5'(sel);
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic rd8(input int sel, input logic [7:0] exp, input string tag);
        dbg_sel8 = 3'(sel);
        #1;
        check(tag, 32'(dbg_data8), 32'(exp));
    endtask

    initial begin
        int  c0;
        int  n;
        logic saw_ret;

        for (int i = 0; i < 64; i++) begin
            mem32[i] = 32'h0;
            mem8[i]  = 32'h0;
        end
        rst = 1'b1; run = 1'b0; run8 = 1'b0;
        ready32 = 1'b1; ready8 = 1'b1;
        dbg_sel = '0; dbg_sel8 = '0;

        // ---------------- reset / idle ----------------
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(if32.imem_req), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_zf", 32'(zf), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_pc8", 32'(pc8), 32'h0000_00F4);
        for (int i = 0; i < 32; i++) rd32(i, 32'h0, "rst_dbg");
        @(negedge clk);
        check("idle_req", 32'(if32.imem_req), 32'd0);

        // ---------------- WIDTH=8 / NREG=8 ----------------
        mem8[61] = enc_i(8, 0, 1, 16'h007F);   // F4: addi r1,r0,0x7F
        mem8[62] = enc_i(8, 1, 1, 1);          // F8: addi r1,r1,1
        mem8[63] = enc_i(8, 0, 2, 3);          // FC: addi r2,r0,3
        mem8[0]  = enc_r(2, 2, 9, 0, 8'h20);   // 00: add r9(->r1),r2,r2
        mem8[1]  = enc_r(0, 2, 2, 7, 8'h00);   // 04: sll r2,r2,7
        run8 = 1'b1;
        wait_ret(1'b1, "w8_i1");
        rd8(1, 8'h7F, "w8_r1_7f");
        wait_ret(1'b1, "w8_i2");
        rd8(1, 8'h80, "w8_r1_80");
        wait_ret(1'b1, "w8_i3");
        check("w8_pc_wrap", 32'(pc8), 32'h0);
        rd8(2, 8'h03, "w8_r2");
        wait_ret(1'b1, "w8_i4");
        run8 = 1'b0;
        rd8(1, 8'h06, "w8_rd9_r1");
        check("w8_pc4", 32'(pc8), 32'h4);
        wait_ret(1'b1, "w8_i5");
        rd8(2, 8'h80, "w8_sll");
        check("w8_pc8", 32'(pc8), 32'h8);
        check("w8_idle_req", 32'(if8.imem_req), 32'd0);

        // ---------------- ALU sequence ----------------
        mem32[0] = enc_i(8, 0, 1, 5);            // addi r1,r0,5
        mem32[1] = enc_i(8, 0, 2, -3);           // addi r2,r0,-3
        mem32[2] = enc_r(1, 2, 3, 0, 8'h20);     // add  r3,r1,r2
        mem32[3] = enc_r(2, 1, 4, 0, 8'h2A);     // slt  r4,r2,r1
        mem32[4] = enc_r(0, 1, 5, 4, 8'h00);     // sll  r5,r1,4
        run = 1'b1;
        wait_ret(1'b0, "alu1");
        rd32(1, 32'd5, "alu_r1");
        wait_ret(1'b0, "alu2");
        check("alu_gap2", 32'(last_cyc - prev_cyc), 32'd4);
        rd32(2, 32'hFFFF_FFFD, "alu_r2");
        wait_ret(1'b0, "alu3");
        check("alu_gap3", 32'(last_cyc - prev_cyc), 32'd4);
        wait_ret(1'b0, "alu4");
        check("alu_gap4", 32'(last_cyc - prev_cyc), 32'd4);
        run = 1'b0;
        wait_ret(1'b0, "alu5");
        check("alu_gap5", 32'(last_cyc - prev_cyc), 32'd4);
        check("alu_pc", pc, 32'd20);
        check("alu_idle_req", 32'(if32.imem_req), 32'd0);
        rd32(3, 32'd2, "alu_r3");
        rd32(4, 32'd1, "alu_r4");
        rd32(5, 32'd80, "alu_r5");
        rd32(0, 32'd0, "alu_r0");

        // ---------------- branches ----------------
        mem32[5]  = enc_i(8, 0, 1, 7);           // 20: addi r1,r0,7
        mem32[6]  = enc_i(8, 0, 2, 7);           // 24: addi r2,r0,7
        mem32[7]  = enc_i(4, 1, 2, 3);           // 28: beq r1,r2,+3
        mem32[11] = enc_i(5, 1, 2, 3);           // 44: bne r1,r2,+3
        mem32[12] = enc_i(4, 1, 2, -1);          // 48: beq r1,r2,-1
        run = 1'b1;
        wait_ret(1'b0, "br1");
        wait_ret(1'b0, "br2");
        check("br_zf_before", 32'(zf), 32'd0);
        wait_ret(1'b0, "beq");
        check("beq_pc", pc, 32'd44);
        check("beq_zf", 32'(zf), 32'd1);
        check("beq_addr", if32.imem_addr, 32'd44);
        wait_ret(1'b0, "bne");
        check("bne_pc", pc, 32'd48);
        check("bne_zf", 32'(zf), 32'd1);
        wait_ret(1'b0, "loop1");
        check("loop1_pc", pc, 32'd48);
        run = 1'b0;
        wait_ret(1'b0, "loop2");
        check("loop2_pc", pc, 32'd48);
        check("loop_idle_req", 32'(if32.imem_req), 32'd0);

        // ---------------- fetch stall ----------------
        mem32[12] = enc_i(8, 0, 6, 9);           // 48: addi r6,r0,9
        ready32 = 1'b0;
        run = 1'b1;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            check("stall_req", 32'(if32.imem_req), 32'd1);
            check("stall_addr", if32.imem_addr, 32'd48);
        end
        ready32 = 1'b1;
        run = 1'b0;
        wait_ret(1'b0, "stall");
        check("stall_cycles", 32'(last_cyc - c0), 32'd9);
        rd32(6, 32'd9, "stall_r6");
        check("stall_pc", pc, 32'd52);

        // ---------------- illegal, HALT, reset ----------------
        mem32[13] = 32'hFC00_0000;               // 52: op 0x3F
        run = 1'b1;
        c0 = cyc;
        n = 0;
        saw_ret = 1'b0;
        while (!illegal && n < 20) begin
            @(negedge clk);
            n++;
            if (retired) saw_ret = 1'b1;
        end
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_latency", 32'(cyc - c0), 32'd4);
        repeat (3) @(negedge clk);
        if (retired) saw_ret = 1'b1;
        check("ill_no_retire", 32'(saw_ret), 32'd0);
        check("halt_req", 32'(if32.imem_req), 32'd0);
        check("halt_sticky", 32'(illegal), 32'd1);
        check("halt_pc", pc, 32'd56);

        ready32 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("hrst_illegal", 32'(illegal), 32'd0);
        check("hrst_pc", pc, 32'd0);
        check("hrst_req", 32'(if32.imem_req), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midfetch_req", 32'(if32.imem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_req", 32'(if32.imem_req), 32'd0);
        check("mrst_pc", pc, 32'd0);
        check("mrst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        check("mrst_idle_req", 32'(if32.imem_req), 32'd0);
        rd32(6, 32'd0, "mrst_r6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
